dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported `data_memory` between the pipeline's memory-access path (CPU port) and a debug/program-loader port (DBG port). It sits between the EX/MEM stage and `data_memory`. It grants at most one access per cycle, gives the CPU fixed priority with a bounded-starvation guarantee for DBG, and routes the one-cycle-latency read data back to the port that issued the read. It also drives the pipeline stall when a CPU request is not granted.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `STARVE_LIMIT`, default 4: consecutive cycles DBG may be refused before it is forced a grant (range 1–15).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  CPU access request; level, held until granted.
- `cpu_we`  in  1  1 = write (store), 0 = read (load).
- `cpu_addr`  in  AW  byte address.
- `cpu_wdata`  in  DW  store data.
- `cpu_gnt`  out  1  access issued to memory this cycle (combinational).
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`; freezes the pipeline.
- `cpu_rvalid`  out  1  load data valid; registered, one cycle after a read grant.
- `cpu_rdata`  out  DW  load data; valid only when `cpu_rvalid` is high.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as the CPU equivalents, for the DBG port.
- `mem_read`  out  1  drives `data_memory` MemRead.
- `mem_write`  out  1  drives `data_memory` MemWrite.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; valid the cycle after `mem_read`.

## Operation
- FSM with 2 states:
  - `CPU_PRI` (reset state): the CPU wins whenever `cpu_req=1`. DBG is granted only when `cpu_req=0`.
  - `DBG_PRI`: DBG wins whenever `dbg_req=1`. After the first DBG grant, the FSM returns to `CPU_PRI`. If `dbg_req` drops before being granted, the FSM also returns to `CPU_PRI`.
- Starvation counter `starve_cnt` (4 bits):
  - Increments each cycle that `dbg_req=1` and `dbg_gnt=0`.
  - Clears on a DBG grant or when `dbg_req=0`.
  - When the counter reaches `STARVE_LIMIT`, the next state is `DBG_PRI` and the counter clears.
- Mux: `mem_addr` and `mem_wdata` come from the granted port. With no grant, they carry CPU values (don't-care). `mem_write = gnt & we`; `mem_read = gnt & ~we`.
- Read return:
  - The flop `rd_owner` (2 bits: none/CPU/DBG) captures the owner of a read grant.
  - The next cycle, the owner's `rvalid` is 1 and its `rdata = mem_rdata`.
  - The non-owner's `rdata` is held at 0.
- Writes complete in the grant cycle. No response is returned.
- Back-to-back accesses are allowed: a new grant may issue in the same cycle a previous read's `rvalid` is high.
- Simultaneous requests:
  - In `CPU_PRI`, only the CPU is granted; DBG sees `dbg_gnt=0` and its counter increments.
  - In `DBG_PRI`, only DBG is granted; `cpu_stall=1` for that cycle.
- The arbiter never grants both ports in one cycle and never issues read and write together.

## Timing
- Grant latency: 0 cycles, combinational from `req` and the FSM state.
- Read data latency: 1 cycle after the grant.
- Worst-case DBG wait under continuous CPU traffic: `STARVE_LIMIT`+1 cycles from `dbg_req` to `dbg_gnt`.
- Worst-case CPU stall from arbitration: 1 cycle per forced DBG grant.
- Reset values (asserted immediately and asynchronously while `rst_n=0`):
  - state = `CPU_PRI`, `starve_cnt` = 0, `rd_owner` = none.
  - `cpu_rvalid` = `dbg_rvalid` = 0.
  - `cpu_gnt`, `dbg_gnt`, `mem_read`, `mem_write` forced to 0.
  - `cpu_rdata` = `dbg_rdata` = 0.
- Reset mid-read: the in-flight `rvalid` is dropped. It is not reissued after reset.

## Structure
- Shared package `pipeline_pkg`: the `rd_owner` encoding constants (`OWN_NONE=0`, `OWN_CPU=1`, `OWN_DBG=2`) and the FSM state constants (`CPU_PRI=0`, `DBG_PRI=1`). Both are reused by the MEM-stage stall logic.
- One natural sub-module: `dmem_starve_ctr`, which holds the saturating starvation counter and the limit compare and outputs `force_dbg`.

## Test plan
- Reset: hold `rst_n=0` with both `req=1` → both `gnt=0`, `mem_read=mem_write=0`, both `rvalid=0`. After release, CPU is granted first.
- CPU store then load:
  - Cycle 0: `cpu_we=1`, `cpu_addr=5`, `cpu_wdata=18` → `mem_write=1`, `mem_addr=5`, `mem_wdata=18`.
  - Cycle 1: read `cpu_addr=5` → cycle 2: `cpu_rvalid=1`, `cpu_rdata=18`, `dbg_rvalid=0`.
- Contention: both request every cycle with `STARVE_LIMIT=4` → CPU granted in cycles 0–3, DBG granted in cycle 4 with `cpu_stall=1`, then CPU again in cycle 5. The pattern repeats every 5 cycles.
- DBG only: `dbg_req` read at `addr=8` holding 0x2A, `cpu_req=0` → `dbg_gnt=1` in the same cycle, `dbg_rvalid=1` with `dbg_rdata=0x2A` the next cycle.
- Back-to-back reads: CPU reads addr 1 then DBG reads addr 2 in consecutive cycles → `cpu_rvalid` then `dbg_rvalid` on consecutive cycles, each with the correct data and never both high.
- Reset mid-read: assert `rst_n=0` in the cycle after a read grant → no `rvalid` pulse appears, and `starve_cnt` returns to 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the MEM-stage arbiter and stall logic: read-return
// owner encoding and arbiter priority-state encoding.
package pipeline_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DBG  = 2'd2;

  localparam logic CPU_PRI = 1'b0;
  localparam logic DBG_PRI = 1'b1;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive cycles the DBG port is refused and flags when the
// next cycle must hand priority to DBG.
module dmem_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_dbg
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic [3:0] cnt_inc;
  logic       waiting;

  assign waiting   = dbg_req & ~dbg_gnt;
  assign cnt_inc   = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
  assign force_dbg = waiting & (cnt_inc == LIMIT);

  // Reaching the limit hands off to the priority FSM, so the count restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!waiting || force_dbg) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU load/store path and
// the debug/loader port, with bounded starvation for DBG.
module dmem_arbiter
  import pipeline_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic       state_q;
  logic       state_d;
  logic [1:0] rd_owner_q;
  logic [1:0] rd_owner_d;
  logic       force_dbg;

  dmem_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .dbg_req  (dbg_req),
    .dbg_gnt  (dbg_gnt),
    .force_dbg(force_dbg)
  );

  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == DBG_PRI) begin
        dbg_gnt = dbg_req;
        cpu_gnt = cpu_req & ~dbg_req;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req & ~cpu_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
  assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
  assign mem_write = (cpu_gnt & cpu_we)  | (dbg_gnt & dbg_we);
  assign mem_read  = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);

  // DBG_PRI always lasts one cycle: either DBG is granted or it withdrew.
  assign state_d = force_dbg ? DBG_PRI : CPU_PRI;

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dbg_gnt && !dbg_we) begin
      rd_owner_d = OWN_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CPU_PRI;
      rd_owner_q <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign dbg_rvalid = (rd_owner_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter: a fairness/memory model
// predicts grants and read data; a monitor pops expected reads on rvalid.
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem_array [16] = '{default: '0};
  logic [DW-1:0] ref_mem   [16] = '{default: '0};
  logic [DW-1:0] cpu_q [$];
  logic [DW-1:0] dbg_q [$];
  int            dbg_wait = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behaves like data_memory: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem_array[mem_addr[3:0]];
    if (mem_write) mem_array[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // One arbitration cycle: drive both ports, predict and check the grant,
  // then queue the read data each granted load must return next cycle.
  task automatic apply_stimulus(input logic c_req, input logic c_we, input logic [AW-1:0] c_addr,
                                input logic [DW-1:0] c_wd, input logic d_req, input logic d_we,
                                input logic [AW-1:0] d_addr, input logic [DW-1:0] d_wd);
    logic exp_cpu, exp_dbg;
    @(posedge clk);
    #1;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    exp_dbg = d_req && (!c_req || dbg_wait >= LIMIT);
    exp_cpu = c_req && !exp_dbg;
    #1;
    check_output("cpu_gnt", cpu_gnt, exp_cpu);
    check_output("dbg_gnt", dbg_gnt, exp_dbg);
    check_output("cpu_stall", cpu_stall, c_req && !exp_cpu);
    check_output("mem_write", mem_write, (exp_cpu && c_we) || (exp_dbg && d_we));
    check_output("mem_read", mem_read, (exp_cpu && !c_we) || (exp_dbg && !d_we));
    if (exp_cpu) begin
      check_output("mem_addr_cpu", mem_addr, c_addr);
      if (c_we) check_output("mem_wdata_cpu", mem_wdata, c_wd);
    end
    if (exp_dbg) begin
      check_output("mem_addr_dbg", mem_addr, d_addr);
      if (d_we) check_output("mem_wdata_dbg", mem_wdata, d_wd);
    end
    if (exp_dbg || !d_req) dbg_wait = 0;
    else dbg_wait++;
    if (exp_cpu) begin
      if (c_we) ref_mem[c_addr[3:0]] = c_wd;
      else cpu_q.push_back(ref_mem[c_addr[3:0]]);
    end
    if (exp_dbg) begin
      if (d_we) ref_mem[d_addr[3:0]] = d_wd;
      else dbg_q.push_back(ref_mem[d_addr[3:0]]);
    end
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: whenever a port presents rvalid, pop its expected data.
  initial begin
    forever begin
      @(negedge clk);
      check_output("rvalid_exclusive", cpu_rvalid & dbg_rvalid, 1'b0);
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL cpu_rvalid_unexpected: got=1 want=0");
        end else check_output("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end else check_output("cpu_rdata_idle", cpu_rdata, '0);
      if (dbg_rvalid) begin
        if (dbg_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL dbg_rvalid_unexpected: got=1 want=0");
        end else check_output("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end else check_output("dbg_rdata_idle", dbg_rdata, '0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with both ports requesting reads.
    cpu_req = 1'b1; dbg_req = 1'b1;
    #12;
    check_output("rst_cpu_gnt", cpu_gnt, 1'b0);
    check_output("rst_dbg_gnt", dbg_gnt, 1'b0);
    check_output("rst_mem_read", mem_read, 1'b0);
    check_output("rst_mem_write", mem_write, 1'b0);
    check_output("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check_output("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(1'b1, 1'b0, 32'd3, '0, 1'b1, 1'b0, 32'd4, '0);
    check_output("first_grant_cpu", cpu_gnt, 1'b1);
    idle_cycle();

    // CPU store then load of address 5.
    apply_stimulus(1'b1, 1'b1, 32'd5, 32'd18, 1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b1, 1'b0, 32'd5, '0, 1'b0, 1'b0, '0, '0);
    idle_cycle();

    // Continuous contention: DBG wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'(i), '0, 1'b1, 1'b0, 32'(15 - i), '0);
      check_output("contention_dbg_gnt", dbg_gnt, (i % 5) == 4);
      check_output("contention_stall", cpu_stall, (i % 5) == 4);
    end
    idle_cycle();

    // DBG-only write then read of address 8.
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd8, 32'h2A);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd8, '0);
    check_output("dbg_only_gnt", dbg_gnt, 1'b1);

    // Back-to-back reads from alternating ports.
    apply_stimulus(1'b1, 1'b0, 32'd1, '0, 1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd2, '0);
    idle_cycle();

    // Reset in the cycle after a CPU read grant, with DBG partly starved.
    apply_stimulus(1'b1, 1'b0, 32'd6, '0, 1'b1, 1'b0, 32'd7, '0);
    apply_stimulus(1'b1, 1'b0, 32'd5, '0, 1'b1, 1'b0, 32'd7, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0;
    cpu_q.delete(); dbg_q.delete();
    dbg_wait = 0;
    #1;
    check_output("midrst_cpu_rvalid", cpu_rvalid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'(i), '0, 1'b1, 1'b0, 32'(i + 8), '0);
      check_output("post_reset_dbg_gnt", dbg_gnt, i == 4);
    end

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)),
                     $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 15)), $urandom);
    end

    repeat (3) idle_cycle();
    @(negedge clk);
    check_output("cpu_q_drained", cpu_q.size(), 0);
    check_output("dbg_q_drained", dbg_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
